motor_relu_seq_ctrl: RTL and testbench

Sequencing controller for the motor-network ReLU activation stage on ap_fixed<18,7> data. It accepts a full N-element vector under an ap_ctrl_hs-style start/ready/done handshake. It passes the elements one per cycle through a single shared ReLU lane and collects the results in an output register bank. The bank is held with a valid/ack handshake until the downstream layer consumes it. This replaces N parallel ReLU comparators with one comparator plus a small sequencer, for area-constrained builds of the motor network.

---
 rtl/motor_nn_pkg.sv | 19 +
 rtl/motor_relu_lane.sv | 20 ++
 rtl/motor_relu_seq_ctrl.sv | 131 +++++++++++++
 tb/tb_motor_relu_seq_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_nn_pkg.sv
// Shared definitions for the motor-network activation stages.
//   W_DEF, I_DEF, N_ELEM_DEF : default element width, integer bits, vector length
//   elem_t                   : one ap_fixed<18,7> element, two's complement
//   state_t                  : sequencer state encoding
package motor_nn_pkg;

    localparam int unsigned W_DEF      = 18;
    localparam int unsigned I_DEF      = 7;
    localparam int unsigned N_ELEM_DEF = 3;

    typedef logic signed [W_DEF-1:0] elem_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HOLD
    } state_t;

endpackage

// File: rtl/motor_relu_lane.sv
// Single-element combinational ReLU lane, shared across all vector elements.
//   x       : input element, two's complement, W bits
//   y       : x when x > 0, otherwise 0
//   clamped : high when x <= 0 (the element was forced to zero)
module motor_relu_lane #(
    parameter int unsigned W = 18
) (
    input  logic [W-1:0] x,
    output logic [W-1:0] y,
    output logic         clamped
);

    logic positive;

    // Strictly positive: sign clear and at least one magnitude bit set.
    assign positive = !x[W-1] && (|x[W-2:0]);
    assign clamped  = !positive;
    assign y        = positive ? {1'b0, x[W-2:0]} : '0;

endmodule

// File: rtl/motor_relu_seq_ctrl.sv
// Sequencing controller for the motor-network ReLU stage. A whole vector is
// captured under a start/ready handshake, streamed one element per cycle
// through one shared ReLU lane, and the result bank is held under valid/ack.
//   ap_clk, ap_rst_n : clock (rising edge), asynchronous active-low reset
//   ap_start         : request to process in_vec
//   ap_ready         : combinational; high in the cycle in_vec is captured
//   ap_idle          : sequencer is idle
//   ap_done          : one-cycle pulse when the result bank becomes valid
//   in_vec           : input vector, element i at [i*W +: W]
//   out_vec          : registered ReLU result, same packing
//   out_vld          : out_vec/zero_cnt valid and held
//   out_ack          : downstream consumed out_vec (only meaningful with out_vld)
//   zero_cnt         : count of elements clamped to zero in the current result
module motor_relu_seq_ctrl
    import motor_nn_pkg::*;
#(
    parameter int unsigned N_ELEM = N_ELEM_DEF,
    parameter int unsigned W      = W_DEF,
    parameter int unsigned I      = I_DEF
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic                         ap_start,
    output logic                         ap_ready,
    output logic                         ap_idle,
    output logic                         ap_done,
    input  logic [N_ELEM*W-1:0]          in_vec,
    output logic [N_ELEM*W-1:0]          out_vec,
    output logic                         out_vld,
    input  logic                         out_ack,
    output logic [$clog2(N_ELEM+1)-1:0]  zero_cnt
);

    localparam int unsigned IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
    localparam int unsigned ZC_W  = $clog2(N_ELEM + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ELEM - 1);

    // I only documents the fixed-point format; reject nonsensical settings.
    if (I < 1 || I > W) begin : g_bad_int_bits
        $error("motor_relu_seq_ctrl: integer bits I must lie in 1..W");
    end

    state_t                 state;
    state_t                 state_nxt;
    logic [IDX_W-1:0]       idx;
    logic [N_ELEM*W-1:0]    in_reg;
    logic                   accept;
    logic                   last;
    logic [W-1:0]           lane_x;
    logic [W-1:0]           lane_y;
    logic                   lane_clamped;

    // A new vector may enter from IDLE, or straight out of HOLD when the
    // current result is consumed in the same cycle.
    assign accept   = ap_start && ((state == ST_IDLE) || ((state == ST_HOLD) && out_ack));
    assign ap_ready = accept && ap_rst_n;
    assign ap_idle  = (state == ST_IDLE);
    assign last     = (idx == IDX_LAST);
    assign lane_x   = in_reg[idx*W +: W];

    motor_relu_lane #(
        .W (W)
    ) u_lane (
        .x       (lane_x),
        .y       (lane_y),
        .clamped (lane_clamped)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (last) state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (accept)       state_nxt = ST_RUN;
                else if (out_ack) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            idx      <= '0;
            in_reg   <= '0;
            out_vec  <= '0;
            zero_cnt <= '0;
            out_vld  <= 1'b0;
            ap_done  <= 1'b0;
        end else begin
            ap_done <= 1'b0;
            if (accept) begin
                // out_vec deliberately keeps its old contents until overwritten.
                in_reg   <= in_vec;
                idx      <= '0;
                zero_cnt <= '0;
                out_vld  <= 1'b0;
            end else begin
                unique case (state)
                    ST_RUN: begin
                        out_vec[idx*W +: W] <= lane_y;
                        if (lane_clamped) zero_cnt <= zero_cnt + ZC_W'(1);
                        if (last) begin
                            out_vld <= 1'b1;
                            ap_done <= 1'b1;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                    ST_HOLD: begin
                        if (out_ack) out_vld <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_motor_relu_seq_ctrl.sv
// Directed/scoreboard bench for motor_relu_seq_ctrl with N_ELEM=3, W=18.
module tb_motor_relu_seq_ctrl;

    localparam int unsigned N  = 3;
    localparam int unsigned WD = 18;
    localparam int unsigned VW = N * WD;

    typedef struct packed {
        logic [VW-1:0] v;
        logic [1:0]    zc;
    } exp_t;

    logic          ap_clk;
    logic          ap_rst_n;
    logic          ap_start;
    logic          ap_ready;
    logic          ap_idle;
    logic          ap_done;
    logic [VW-1:0] in_vec;
    logic [VW-1:0] out_vec;
    logic          out_vld;
    logic          out_ack;
    logic [1:0]    zero_cnt;

    int unsigned passed;
    int unsigned failed;
    int unsigned total;
    exp_t        sb[$];

    motor_relu_seq_ctrl #(
        .N_ELEM (N),
        .W      (WD),
        .I      (7)
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .ap_start (ap_start),
        .ap_ready (ap_ready),
        .ap_idle  (ap_idle),
        .ap_done  (ap_done),
        .in_vec   (in_vec),
        .out_vec  (out_vec),
        .out_vld  (out_vld),
        .out_ack  (out_ack),
        .zero_cnt (zero_cnt)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference ReLU: y = x > 0 ? x : 0, counting every x <= 0.
    function automatic exp_t model(input logic [VW-1:0] v);
        exp_t r;
        logic signed [WD-1:0] x;
        r = '0;
        for (int i = 0; i < N; i++) begin
            x = v[i*WD +: WD];
            if (x > 0) begin
                r.v[i*WD +: WD] = x;
            end else begin
                r.v[i*WD +: WD] = '0;
                r.zc = r.zc + 2'd1;
            end
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // Present a vector, expect it accepted this cycle, step past the accept edge.
    task automatic start_vec(input string tag, input logic [VW-1:0] v);
        ap_start = 1'b1;
        in_vec   = v;
        #1;
        chk({tag, "_ready"}, 64'(ap_ready), 64'd1);
        sb.push_back(model(v));
        tick();
        ap_start = 1'b0;
    endtask

    // Wait (bounded) for ap_done; check latency and the scoreboard head.
    task automatic expect_result(input string tag, input int unsigned lat);
        int unsigned cyc;
        exp_t e;
        cyc = 0;
        while (ap_done !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'(lat));
        chk({tag, "_vld"}, 64'(out_vld), 64'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_out_vec"}, 64'(out_vec), 64'(e.v));
            chk({tag, "_zero_cnt"}, 64'(zero_cnt), 64'(e.zc));
        end
    endtask

    task automatic ack_to_idle(input string tag);
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        chk({tag, "_vld_clr"}, 64'(out_vld), 64'd0);
        chk({tag, "_idle"}, 64'(ap_idle), 64'd1);
    endtask

    initial begin
        logic [VW-1:0] held;
        logic [VW-1:0] v;
        logic          saw_done;

        passed   = 0;
        failed   = 0;
        total    = 0;
        ap_rst_n = 1'b0;
        ap_start = 1'b1;
        out_ack  = 1'b0;
        in_vec   = '1;

        // Reset state, ap_ready gated even with ap_start high
        #2;
        chk("rst_idle", 64'(ap_idle), 64'd1);
        chk("rst_ready", 64'(ap_ready), 64'd0);
        chk("rst_done", 64'(ap_done), 64'd0);
        chk("rst_vld", 64'(out_vld), 64'd0);
        chk("rst_out_vec", 64'(out_vec), 64'd0);
        chk("rst_zero_cnt", 64'(zero_cnt), 64'd0);
        ap_start = 1'b0;
        tick();
        tick();
        ap_rst_n = 1'b1;
        tick();

        // Basic vector {0x00100, 0x3FF00, 0x00000}
        start_vec("basic", {18'h00100, 18'h3FF00, 18'h00000});
        chk("basic_busy", 64'(ap_idle), 64'd0);
        expect_result("basic", 3);
        chk("basic_expl_vec", 64'(out_vec), 64'({18'h00100, 18'h00000, 18'h00000}));
        chk("basic_expl_zc", 64'(zero_cnt), 64'd2);
        tick();
        chk("basic_done_pulse", 64'(ap_done), 64'd0);
        chk("basic_vld_held", 64'(out_vld), 64'd1);
        ack_to_idle("basic");

        // Extremes: max, min, -1
        start_vec("ext", {18'h1FFFF, 18'h20000, 18'h3FFFF});
        expect_result("ext", 3);
        chk("ext_expl_vec", 64'(out_vec), 64'({18'h1FFFF, 18'h00000, 18'h00000}));

        // Backpressure: stall in HOLD with ap_start asserted
        held = out_vec;
        ap_start = 1'b1;
        in_vec = {18'h00055, 18'h00066, 18'h00077};
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("bp_ready", 64'(ap_ready), 64'd0);
            tick();
            chk("bp_vec", 64'(out_vec), 64'(held));
            chk("bp_vld", 64'(out_vld), 64'd1);
            chk("bp_done", 64'(ap_done), 64'd0);
        end
        // Same-cycle ack + start
        out_ack = 1'b1;
        start_vec("bpacc", {18'h00001, 18'h00002, 18'h20001});
        out_ack = 1'b0;
        chk("bpacc_vld_low", 64'(out_vld), 64'd0);
        expect_result("bpacc", 3);
        chk("bpacc_expl_vec", 64'(out_vec), 64'({18'h00001, 18'h00002, 18'h00000}));
        chk("bpacc_expl_zc", 64'(zero_cnt), 64'd1);
        ack_to_idle("bpacc");

        // ap_start during RUN with a different vector is ignored
        start_vec("run", {18'h0ABCD, 18'h30000, 18'h12345});
        ap_start = 1'b1;
        in_vec = {18'h00011, 18'h00022, 18'h00033};
        #1;
        chk("run_ign_ready0", 64'(ap_ready), 64'd0);
        tick();
        chk("run_ign_ready1", 64'(ap_ready), 64'd0);
        ap_start = 1'b0;
        expect_result("run", 2);
        chk("run_expl_vec", 64'(out_vec), 64'({18'h0ABCD, 18'h00000, 18'h12345}));
        ack_to_idle("run");

        // Asynchronous reset at the second RUN cycle
        start_vec("abort", {18'h00700, 18'h00800, 18'h00900});
        tick();
        ap_start = 1'b1;
        #2;
        ap_rst_n = 1'b0;
        #1;
        chk("abort_idle", 64'(ap_idle), 64'd1);
        chk("abort_ready", 64'(ap_ready), 64'd0);
        chk("abort_vld", 64'(out_vld), 64'd0);
        chk("abort_done", 64'(ap_done), 64'd0);
        chk("abort_vec", 64'(out_vec), 64'd0);
        chk("abort_zc", 64'(zero_cnt), 64'd0);
        void'(sb.pop_front());
        ap_start = 1'b0;
        tick();
        ap_rst_n = 1'b1;
        saw_done = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (ap_done === 1'b1) saw_done = 1'b1;
        end
        chk("abort_no_done", 64'(saw_done), 64'd0);
        chk("abort_idle_after", 64'(ap_idle), 64'd1);

        // Back-to-back: ack tied high, start held high, one result per 4 cycles
        out_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            v = {18'($urandom), 18'($urandom), 18'($urandom)};
            if (k == 2) v[17:0] = '0;
            start_vec("b2b", v);
            ap_start = 1'b1;
            expect_result("b2b", 3);
        end
        ap_start = 1'b0;
        tick();
        chk("b2b_idle", 64'(ap_idle), 64'd1);
        chk("b2b_vld_clr", 64'(out_vld), 64'd0);
        out_ack = 1'b0;
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
